pc_sequencer: RTL

//  Controller that drives fetch's pc_place/pc_select/index each cycle. Arbitrates PC sources (reset boot,

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/pc_sequencer_int_pending_reg.sv | 25 ++
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: fetch place codes, sequential step codes and FSM states.
// Fetch and the control unit import the same package so the codes cannot drift apart.
package pc_sequencer_pkg;

    localparam logic [3:0] PLACE_SEQ     = 4'b0000;
    localparam logic [3:0] PLACE_ZERO    = 4'b0001;
    localparam logic [3:0] PLACE_TWO     = 4'b0010;
    localparam logic [3:0] PLACE_IVT_IDX = 4'b0101;
    localparam logic [3:0] PLACE_RET     = 4'b0110;
    localparam logic [3:0] PLACE_CALL    = 4'b0111;
    localparam logic [3:0] PLACE_MEM     = 4'b1000;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_INC1 = 2'b01;
    localparam logic [1:0] SEL_INC2 = 2'b10;

    typedef enum logic [2:0] {
        ST_RST_VEC   = 3'd0,
        ST_RST_LOAD  = 3'd1,
        ST_RUN       = 3'd2,
        ST_INT_DRAIN = 3'd3,
        ST_INT_VEC   = 3'd4,
        ST_INT_LOAD  = 3'd5
    } pc_seq_state_t;

endpackage

// File: rtl/pc_sequencer_int_pending_reg.sv
// Holds one outstanding interrupt request and its IVT index until the vector is loaded.
// A set in the same cycle as the clear wins, so a request arriving during the vector load is kept.
module int_pending_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       set,
    input  logic [2:0] set_index,
    input  logic       clear,
    output logic       pending,
    output logic [2:0] pending_index
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending       <= 1'b0;
            pending_index <= 3'd0;
        end else if (set) begin
            pending       <= 1'b1;
            pending_index <= set_index;
        end else if (clear) begin
            pending       <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Per-cycle PC-source arbiter for fetch, plus the multi-cycle boot and interrupt-entry sequences.
// Redirects in RUN are decoded combinationally so fetch latches them on the same edge.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int         DRAIN_CYCLES = 3,
    parameter logic [3:0] IVT_PLACE    = 4'b0010
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          two_word,
    input  logic          jump_req,
    input  logic          call_req,
    input  logic          ret_req,
    input  logic          int_req,
    input  logic [2:0]    int_index,
    output logic [3:0]    pc_place,
    output logic [1:0]    pc_select,
    output logic [2:0]    index,
    output logic          flush,
    output logic          int_save,
    output logic          int_ack,
    output logic          busy,
    output pc_seq_state_t state_dbg
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    pc_seq_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q;
    logic [2:0]    pend_idx;
    logic          int_set;
    logic          int_clr;
    logic          take_int;

    // Requests are accepted only in RUN with nothing pending, or during the vector load itself.
    assign int_set = int_req && (((state_q == ST_RUN) && !pend_q) || (state_q == ST_INT_LOAD));
    assign int_clr = (state_q == ST_INT_LOAD);

    // A fresh request is taken in its own cycle when nothing else competes for the PC.
    assign take_int = (state_q == ST_RUN) && (pend_q || int_req) &&
                      !ret_req && !call_req && !jump_req && !stall;

    assign state_dbg = state_q;

    int_pending_reg u_pending (
        .clk           (clk),
        .reset         (reset),
        .set           (int_set),
        .set_index     (int_index),
        .clear         (int_clr),
        .pending       (pend_q),
        .pending_index (pend_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RST_VEC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_place  = PLACE_SEQ;
        pc_select = SEL_HOLD;
        index     = 3'd0;
        flush     = 1'b0;
        int_save  = 1'b0;
        int_ack   = 1'b0;
        busy      = 1'b0;

        case (state_q)
            ST_RST_VEC: begin
                pc_place = PLACE_ZERO;
                flush    = 1'b1;
                busy     = 1'b1;
                state_d  = ST_RST_LOAD;
            end
            ST_RST_LOAD: begin
                pc_place = PLACE_MEM;
                flush    = 1'b1;
                busy     = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (take_int) begin
                    int_save = 1'b1;
                    cnt_d    = CW'(DRAIN_CYCLES - 1);
                    state_d  = ST_INT_DRAIN;
                end else if (ret_req) begin
                    pc_place = PLACE_RET;
                    flush    = 1'b1;
                end else if (call_req) begin
                    pc_place = PLACE_CALL;
                    flush    = 1'b1;
                end else if (jump_req) begin
                    pc_place = PLACE_MEM;
                    flush    = 1'b1;
                end else if (stall) begin
                    pc_select = SEL_HOLD;
                end else if (two_word) begin
                    pc_select = SEL_INC2;
                end else begin
                    pc_select = SEL_INC1;
                end
            end
            ST_INT_DRAIN: begin
                flush = 1'b1;
                busy  = 1'b1;
                // Stalled cycles do not retire anything, so they do not count toward the drain.
                if (!stall) begin
                    if (cnt_q == '0) begin
                        state_d = ST_INT_VEC;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_INT_VEC: begin
                pc_place = IVT_PLACE;
                flush    = 1'b1;
                busy     = 1'b1;
                state_d  = ST_INT_LOAD;
            end
            ST_INT_LOAD: begin
                pc_place = PLACE_IVT_IDX;
                index    = pend_idx;
                flush    = 1'b1;
                int_ack  = 1'b1;
                busy     = 1'b1;
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_RST_VEC;
            end
        endcase
    end

endmodule
